// File: rtl/pwm_ctrl_pkg.sv
// Shared constants for the PWM duty ramp controller: widths, defaults,
// FSM state encoding, manual-request pending encoding and a saturating step.
package pwm_ctrl_pkg;

  localparam int DUTY_W        = 7;
  localparam int DIV_W         = 4;
  localparam int DUTY_MAX_DEF  = 127;
  localparam int DUTY_INIT_DEF = 63;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Pending manual request encoding
  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_INC  = 2'd1;
  localparam logic [1:0] PEND_DEC  = 2'd2;

  // One duty step up or down, clamped to [0, maxv]
  function automatic logic [DUTY_W-1:0] sat_step(input logic [DUTY_W-1:0] d,
                                                  input logic              up,
                                                  input logic [DUTY_W-1:0] maxv);
    logic [DUTY_W-1:0] r;
    if (up) r = (d >= maxv) ? maxv : d + 1'b1;
    else    r = (d == '0)   ? '0   : d - 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Period divider for ramps: counts qualified period_end pulses and flags the
// one on which a duty step is due (every div+1 pulses).
module pwm_step_timer
  import pwm_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             period_end,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             step_due
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign step_due = period_end && (div_cnt_q == div);

  // Next count: restart on clear or on a due step, otherwise count pulses
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear || step_due) div_cnt_d = '0;
    else if (period_end)   div_cnt_d = div_cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle controller for a PWM engine. Ramps duty_out toward a target one
// step per (step_div+1) PWM periods, or nudges it by manual +1/-1 requests.
// Every duty change lands on the edge that samples period_end.
//
// Pulse protocol: start, abort, inc_req, dec_req and period_end are single
// cycle strobes with no back-pressure; a strobe is consumed in the cycle it is
// high or dropped if the FSM state does not accept it. duty_load and done are
// single-cycle strobes out, aligned with the cycle the new state is visible.
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_MAX  = DUTY_MAX_DEF,
  parameter int DUTY_INIT = DUTY_INIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              period_end,
  input  logic              start,
  input  logic              abort,
  input  logic [DUTY_W-1:0] target,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              inc_req,
  input  logic              dec_req,
  output logic [DUTY_W-1:0] duty_out,
  output logic              duty_load,
  output logic              busy,
  output logic              done,
  output logic              at_max,
  output logic              at_min,
  output logic [1:0]        fsm_state_o
);

  localparam logic [DUTY_W-1:0] MAXV  = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INITV = DUTY_W'(DUTY_INIT);

  logic [1:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        pend_q, pend_d;
  logic              load_q, load_d;

  logic              start_ok;
  logic              step_due;
  logic [DUTY_W-1:0] tgt_cap;
  logic [DUTY_W-1:0] man_val;
  logic [DUTY_W-1:0] ramp_val;

  assign start_ok = (state_q == ST_IDLE) && start && !abort;
  assign tgt_cap  = (target > MAXV) ? MAXV : target;
  assign man_val  = sat_step(duty_q, pend_q == PEND_INC, MAXV);
  assign ramp_val = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;

  // Only periods seen while ramping advance the divider
  pwm_step_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .period_end (period_end && (state_q == ST_RAMP)),
    .clear      (start_ok),
    .div        (div_q),
    .step_due   (step_due)
  );

  // FSM, ramp stepping and manual pending handling
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    div_d   = div_q;
    pend_d  = pend_q;
    load_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          tgt_d   = tgt_cap;
          div_d   = step_div;
          pend_d  = PEND_NONE;
          state_d = (tgt_cap != duty_q) ? ST_RAMP : ST_DONE;
        end else begin
          // Apply an older pending request first; a request arriving in the
          // same cycle becomes the new pending value.
          if (period_end && (pend_q != PEND_NONE)) begin
            pend_d = PEND_NONE;
            if (man_val != duty_q) begin
              duty_d = man_val;
              load_d = 1'b1;
            end
          end
          if (inc_req && dec_req) pend_d = PEND_NONE;
          else if (inc_req)       pend_d = PEND_INC;
          else if (dec_req)       pend_d = PEND_DEC;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (step_due) begin
          duty_d = ramp_val;
          load_d = 1'b1;
          if (ramp_val == tgt_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      duty_q  <= INITV;
      tgt_q   <= INITV;
      div_q   <= '0;
      pend_q  <= PEND_NONE;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
    end
  end

  assign duty_out    = duty_q;
  assign duty_load   = load_q;
  assign busy        = (state_q == ST_RAMP);
  assign done        = (state_q == ST_DONE);
  assign at_max      = (duty_q == MAXV);
  assign at_min      = (duty_q == '0);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramp/abort/reset scenarios plus a short
// random run of manual requests, with a queue of expected duty loads.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       period_end, start, abort, inc_req, dec_req;
  logic [6:0] target;
  logic [3:0] step_div;
  logic [6:0] duty_out;
  logic       duty_load, busy, done, at_max, at_min;
  logic [1:0] fsm_state;

  logic [6:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_seen = 0;
  int         exp_done = 0;
  logic       pe_prev = 1'b0;

  pwm_ramp_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .period_end  (period_end),
    .start       (start),
    .abort       (abort),
    .target      (target),
    .step_div    (step_div),
    .inc_req     (inc_req),
    .dec_req     (dec_req),
    .duty_out    (duty_out),
    .duty_load   (duty_load),
    .busy        (busy),
    .done        (done),
    .at_max      (at_max),
    .at_min      (at_min),
    .fsm_state_o (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pe_edge();
    period_end = 1'b1;
    tick();
    period_end = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic do_start(input int tgt, input int dv);
    target   = 7'(tgt);
    step_div = 4'(dv);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // scoreboard: every duty_load must match the next queued duty and follow
  // an edge that sampled period_end
  always @(posedge clk) pe_prev <= period_end;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (duty_load) begin
      check("load_on_period_end", int'(pe_prev), 1);
      if (exp_q.size() == 0) check("unexpected_load", int'(duty_out), -1);
      else                   check("load_value", int'(duty_out), int'(exp_q.pop_front()));
    end
  end

  initial begin
    int m_duty;
    int r;
    reset = 1'b1; period_end = 1'b0; start = 1'b0; abort = 1'b0;
    inc_req = 1'b0; dec_req = 1'b0; target = '0; step_div = '0;
    repeat (3) tick();
    check("rst_duty", duty_out, 63);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", duty_load, 0);
    check("rst_state", fsm_state, 0);
    reset = 1'b0;

    // idle periods leave duty alone
    repeat (3) begin pe_edge(); gap(); end
    check("idle_duty", duty_out, 63);
    check("idle_at_min", at_min, 0);
    check("idle_at_max", at_max, 0);

    // ramp 63 -> 66, one step every 2nd period
    exp_q.push_back(7'd64); exp_q.push_back(7'd65); exp_q.push_back(7'd66);
    do_start(66, 1);
    check("ramp_busy", busy, 1);
    check("ramp_no_move", duty_out, 63);
    for (int k = 1; k <= 6; k++) begin
      gap();
      pe_edge();
      if (k == 6) begin
        check("ramp_end_duty", duty_out, 66);
        check("ramp_end_done", done, 1);
        check("ramp_end_busy", busy, 0);
        exp_done++;
      end else begin
        check("ramp_step_duty", duty_out, 63 + k / 2);
        check("ramp_step_load", duty_load, (k % 2 == 0) ? 1 : 0);
      end
    end
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);

    // ramp down to 0 every period
    for (int v = 65; v >= 0; v--) exp_q.push_back(7'(v));
    do_start(0, 0);
    for (int k = 0; k < 66; k++) begin
      pe_edge();
      if ($urandom_range(0, 1) == 1) tick();
    end
    exp_done++;
    tick();
    check("down_duty", duty_out, 0);
    check("down_at_min", at_min, 1);

    // start to the current duty: done next cycle, no load
    do_start(0, 3);
    check("same_tgt_done", done, 1);
    check("same_tgt_busy", busy, 0);
    exp_done++;
    tick();
    check("same_tgt_done_off", done, 0);

    // dec at 0 saturates, no load
    dec_req = 1'b1; tick(); dec_req = 1'b0;
    pe_edge();
    check("dec_sat_duty", duty_out, 0);
    check("dec_sat_load", duty_load, 0);

    // inc+dec together cancel
    inc_req = 1'b1; dec_req = 1'b1; tick(); inc_req = 1'b0; dec_req = 1'b0;
    pe_edge();
    check("both_duty", duty_out, 0);
    // inc alone applies once
    exp_q.push_back(7'd1);
    inc_req = 1'b1; tick(); inc_req = 1'b0;
    gap();
    pe_edge();
    check("inc_duty", duty_out, 1);
    check("inc_load", duty_load, 1);
    pe_edge();
    check("inc_once", duty_out, 1);
    // newer request overwrites older
    exp_q.push_back(7'd0);
    inc_req = 1'b1; tick(); inc_req = 1'b0;
    dec_req = 1'b1; tick(); dec_req = 1'b0;
    pe_edge();
    check("overwrite_duty", duty_out, 0);

    // ramp up to the top and saturate inc
    for (int v = 1; v <= 127; v++) exp_q.push_back(7'(v));
    do_start(127, 0);
    repeat (127) pe_edge();
    exp_done++;
    tick();
    check("top_duty", duty_out, 127);
    check("top_at_max", at_max, 1);
    inc_req = 1'b1; tick(); inc_req = 1'b0;
    pe_edge();
    check("inc_sat_duty", duty_out, 127);
    check("inc_sat_load", duty_load, 0);

    // abort after 5 steps, colliding with a due step
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst2_duty", duty_out, 63);
    for (int v = 64; v <= 68; v++) exp_q.push_back(7'(v));
    do_start(100, 0);
    repeat (5) begin pe_edge(); gap(); end
    abort = 1'b1; period_end = 1'b1; tick(); abort = 1'b0; period_end = 1'b0;
    check("abort_duty", duty_out, 68);
    check("abort_busy", busy, 0);
    check("abort_load", duty_load, 0);
    check("abort_done", done, 0);
    pe_edge();
    check("abort_hold", duty_out, 68);

    // start and abort together in idle: start ignored
    abort = 1'b1; do_start(10, 0); abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_done", done, 0);
    pe_edge();
    check("start_abort_duty", duty_out, 68);

    // slowest divider; period_end with the start does not count
    exp_q.push_back(7'd69);
    period_end = 1'b1; do_start(69, 15); period_end = 1'b0;
    check("div15_busy", busy, 1);
    repeat (15) pe_edge();
    check("div15_wait", duty_out, 68);
    pe_edge();
    check("div15_step", duty_out, 69);
    check("div15_done", done, 1);
    exp_done++;
    tick();

    // reset mid-ramp
    exp_q.push_back(7'd70); exp_q.push_back(7'd71);
    do_start(100, 0);
    repeat (2) pe_edge();
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_duty", duty_out, 63);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    // pending request lost across reset
    inc_req = 1'b1; tick(); inc_req = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    pe_edge();
    check("rst_pend_none", duty_out, 63);

    // random manual requests
    m_duty = 63;
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 2);
      inc_req = (r != 1); dec_req = (r != 0);
      tick();
      inc_req = 1'b0; dec_req = 1'b0;
      gap();
      if (r == 0 && m_duty < 127) begin m_duty++; exp_q.push_back(7'(m_duty)); end
      if (r == 1 && m_duty > 0)   begin m_duty--; exp_q.push_back(7'(m_duty)); end
      pe_edge();
      check("rand_duty", duty_out, m_duty);
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    check("done_count", done_seen, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
